// File: rtl/mcrv_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset core:
// FSM states, opcode/funct constants, ALU control and immediate formats.
package mcrv_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LW     = 7'b0000011;
    localparam logic [6:0] OP_SW     = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_J
    } imm_fmt_t;

    function automatic alu_ctrl_t alu_from_f3(input logic [2:0] f3, input logic sub);
        case (f3)
            F3_ADD:  return sub ? ALU_SUB : ALU_ADD;
            F3_SLT:  return ALU_SLT;
            F3_OR:   return ALU_OR;
            F3_AND:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mcrv_regfile.sv
// Architectural register file: two asynchronous read ports, one synchronous
// write port, register 0 reads as zero and discards writes.
module mcrv_regfile #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned REG_COUNT = 32,
    parameter int unsigned AW        = $clog2(REG_COUNT)
) (
    input  logic             clk,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2 = (ra2 == '0) ? '0 : regs[ra2];

endmodule

// File: rtl/multi_cycle_riscv.sv
// Multi-cycle RV32I-subset core sharing one ALU and one memory port.
// Define MCRV_ILLEGAL_TRAP_EN to halt on illegal instructions instead of skipping them.
//
// state      | meaning
// FETCH      | request instruction at PC, PC <= PC+4 on ready
// DECODE     | latch A/B, precompute branch target into ALUOut
// MEMADR     | ALUOut <= A + immI/immS
// MEMREAD    | load request at ALUOut, MDR <= rdata on ready
// MEMWB      | rd <= MDR
// MEMWRITE   | store request of B at ALUOut
// EXEC_R     | ALUOut <= A op B
// EXEC_I     | ALUOut <= A op immI
// ALUWB      | rd <= ALUOut
// BRANCH     | A-B compare, PC <= ALUOut when taken
// JAL        | rd <= PC, PC <= OldPC + immJ
// TRAP       | illegal instruction (halt or skip)
module multi_cycle_riscv
    import mcrv_pkg::*;
#(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned      REG_COUNT = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] alu_result,
    output logic             halted
);

    localparam int unsigned      AW   = $clog2(REG_COUNT);
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    state_t           state, state_nx;
    logic [WIDTH-1:0] pc, old_pc, mdr, a, b, alu_out;
    logic [31:0]      ir;

    logic [6:0]       opcode, funct7;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] rs1_data, rs2_data;

    logic             legal;
    alu_ctrl_t        exec_op;
    imm_fmt_t         imm_fmt;
    logic [31:0]      imm_sel;
    logic [WIDTH-1:0] imm_w;

    logic [WIDTH-1:0] alu_a, alu_b, alu_y;
    alu_ctrl_t        alu_op;
    logic             alu_zero, br_taken;

    logic             req, we, rf_we;
    logic [WIDTH-1:0] addr, rf_wd;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];

    mcrv_regfile #(
        .WIDTH     (WIDTH),
        .REG_COUNT (REG_COUNT),
        .AW        (AW)
    ) u_regfile (
        .clk (clk),
        .ra1 (ir[15 +: AW]),
        .ra2 (ir[20 +: AW]),
        .rd1 (rs1_data),
        .rd2 (rs2_data),
        .we  (rf_we),
        .wa  (ir[7 +: AW]),
        .wd  (rf_wd)
    );

    // funct7[5] only selects sub for R-type; in I-type it is immediate bit 10
    always_comb begin
        legal   = 1'b0;
        exec_op = alu_from_f3(funct3, (opcode == OP_RTYPE) && funct7[5]);
        case (opcode)
            OP_LW, OP_SW: legal = (funct3 == F3_WORD);
            OP_RTYPE: begin
                case (funct3)
                    F3_ADD:                legal = (funct7 == F7_BASE) || (funct7 == F7_SUB);
                    F3_SLT, F3_OR, F3_AND: legal = (funct7 == F7_BASE);
                    default:               legal = 1'b0;
                endcase
            end
            OP_ITYPE:  legal = (funct3 == F3_ADD) || (funct3 == F3_SLT) ||
                               (funct3 == F3_OR)  || (funct3 == F3_AND);
            OP_BRANCH: legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
            OP_JAL:    legal = 1'b1;
            default:   legal = 1'b0;
        endcase
    end

    always_comb begin
        imm_fmt = IMM_I;
        case (state)
            S_DECODE: imm_fmt = IMM_B;
            S_MEMADR: imm_fmt = (opcode == OP_SW) ? IMM_S : IMM_I;
            S_JAL:    imm_fmt = IMM_J;
            default:  imm_fmt = IMM_I;
        endcase
    end

    always_comb begin
        imm_sel = '0;
        case (imm_fmt)
            IMM_I:   imm_sel = {{20{ir[31]}}, ir[31:20]};
            IMM_S:   imm_sel = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_B:   imm_sel = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_J:   imm_sel = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: imm_sel = '0;
        endcase
    end

    assign imm_w = WIDTH'($signed(imm_sel));

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = alu_a + alu_b;
            ALU_SUB: alu_y = alu_a - alu_b;
            ALU_AND: alu_y = alu_a & alu_b;
            ALU_OR:  alu_y = alu_a | alu_b;
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = alu_a + alu_b;
        endcase
    end

    assign alu_zero = (alu_y == '0);
    assign br_taken = (funct3 == F3_BNE) ? !alu_zero : alu_zero;

    always_comb begin
        state_nx = state;
        alu_a    = a;
        alu_b    = b;
        alu_op   = ALU_ADD;
        req      = 1'b0;
        we       = 1'b0;
        addr     = alu_out;
        rf_we    = 1'b0;
        rf_wd    = alu_out;
        case (state)
            S_FETCH: begin
                req   = 1'b1;
                addr  = pc;
                alu_a = pc;
                alu_b = FOUR;
                if (mem_ready) state_nx = S_DECODE;
            end
            S_DECODE: begin
                alu_a = old_pc;
                alu_b = imm_w;
                if (!legal) begin
                    state_nx = S_TRAP;
                end else begin
                    case (opcode)
                        OP_LW, OP_SW: state_nx = S_MEMADR;
                        OP_RTYPE:     state_nx = S_EXEC_R;
                        OP_ITYPE:     state_nx = S_EXEC_I;
                        OP_BRANCH:    state_nx = S_BRANCH;
                        OP_JAL:       state_nx = S_JAL;
                        default:      state_nx = S_TRAP;
                    endcase
                end
            end
            S_MEMADR: begin
                alu_b    = imm_w;
                state_nx = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                req = 1'b1;
                if (mem_ready) state_nx = S_MEMWB;
            end
            S_MEMWB: begin
                rf_we    = 1'b1;
                rf_wd    = mdr;
                state_nx = S_FETCH;
            end
            S_MEMWRITE: begin
                req = 1'b1;
                we  = 1'b1;
                if (mem_ready) state_nx = S_FETCH;
            end
            S_EXEC_R: begin
                alu_op   = exec_op;
                state_nx = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_b    = imm_w;
                alu_op   = exec_op;
                state_nx = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we    = 1'b1;
                state_nx = S_FETCH;
            end
            S_BRANCH: begin
                alu_op   = ALU_SUB;
                state_nx = S_FETCH;
            end
            S_JAL: begin
                alu_a    = old_pc;
                alu_b    = imm_w;
                rf_we    = 1'b1;
                rf_wd    = pc;
                state_nx = S_FETCH;
            end
`ifdef MCRV_ILLEGAL_TRAP_EN
            S_TRAP:  state_nx = S_TRAP;
`else
            S_TRAP:  state_nx = S_FETCH;
`endif
            default: state_nx = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            old_pc  <= '0;
            ir      <= '0;
            mdr     <= '0;
            a       <= '0;
            b       <= '0;
            alu_out <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir     <= 32'(mem_rdata);
                        old_pc <= pc;
                        pc     <= alu_y;
                    end
                end
                S_DECODE: begin
                    a       <= rs1_data;
                    b       <= rs2_data;
                    alu_out <= alu_y;
                end
                S_MEMADR, S_EXEC_R, S_EXEC_I: alu_out <= alu_y;
                S_MEMREAD: begin
                    if (mem_ready) mdr <= mem_rdata;
                end
                S_BRANCH: begin
                    if (br_taken) pc <= alu_out;
                end
                S_JAL:   pc <= alu_y;
                default: ;
            endcase
        end
    end

    // Gate with rst so the bus is idle while reset is held, even though state sits in FETCH
    assign mem_req    = req & ~rst;
    assign mem_we     = we & ~rst;
    assign mem_addr   = {addr[WIDTH-1:2], 2'b00};
    assign mem_wdata  = b;
    assign pc_out     = pc;
    assign alu_result = alu_out;

`ifdef MCRV_ILLEGAL_TRAP_EN
    assign halted = (state == S_TRAP);
`else
    assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_riscv.sv
// Self-checking bench for multi_cycle_riscv: table-driven program with
// per-instruction cycle/PC/register checks plus wait-state and reset sequences.
module tb_multi_cycle_riscv;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic [31:0] pc_out;
    logic [31:0] alu_result;
    logic        halted;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] mem [128];
    int          wait_n = 0;
    int          wcnt   = 0;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        int          cycles;
        int          skip;
        logic [31:0] next_pc;
        int          rd;
        logic [31:0] rd_val;
    } vec_t;

    vec_t tbl[17];

    multi_cycle_riscv #(
        .WIDTH     (32),
        .RESET_PC  (32'h0),
        .REG_COUNT (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc_out     (pc_out),
        .alu_result (alu_result),
        .halted     (halted)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Memory model: each request is held off wait_n cycles before ready.
    always @(negedge clk) begin
        if (mem_req) begin
            if (wcnt < wait_n) begin
                mem_ready = 1'b0;
                mem_rdata = 32'hDEADBEEF;
                wcnt++;
            end else begin
                mem_ready = 1'b1;
                mem_rdata = mem[mem_addr[8:2]];
                if (mem_we) mem[mem_addr[8:2]] = mem_wdata;
                wcnt = 0;
            end
        end else begin
            mem_ready = 1'b0;
            wcnt = 0;
        end
    end

    // Request signals must hold while an access is stalled.
    logic        p_req = 0, p_rdy = 0, p_we = 0;
    logic [31:0] p_addr = 0, p_wd = 0;
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst && p_req && !p_rdy) begin
                n_chk++;
                if (!(mem_req === 1'b1 && mem_we === p_we && mem_addr === p_addr &&
                      (!p_we || mem_wdata === p_wd))) begin
                    n_fail++;
                    $display("FAIL req_stable: actual req=%b we=%b addr=%h wdata=%h required req=1 we=%b addr=%h wdata=%h",
                             mem_req, mem_we, mem_addr, mem_wdata, p_we, p_addr, p_wd);
                end
            end
            p_req  = mem_req && !rst;
            p_rdy  = mem_ready;
            p_we   = mem_we;
            p_addr = mem_addr;
            p_wd   = mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_alu_result", alu_result, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("first_fetch_req", 32'(mem_req), 32'h1);
        chk("first_fetch_addr", mem_addr, 32'h0);
    endtask

    // Called on the first cycle of an instruction's fetch; returns on the first
    // cycle of the next fetch, skipping `skip` intermediate load requests.
    task automatic step(input string nm, input int exp_cyc, input int skip,
                        input logic [31:0] exp_next);
        int   cyc;
        int   seen;
        bit   found;
        logic prev_done;
        cyc   = 1;
        seen  = 0;
        found = 0;
        while (!found && cyc < 64) begin
            prev_done = !mem_req || mem_ready;
            tick();
            cyc++;
            if (mem_req && !mem_we && prev_done) begin
                if (seen == skip) found = 1;
                else seen++;
            end
        end
        if (!found) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: actual no fetch after %0d cycles required %0d cycles", nm, cyc, exp_cyc);
        end else begin
            chk({nm, "_cycles"}, 32'(cyc - 1), 32'(exp_cyc));
            chk({nm, "_next_pc"}, mem_addr, exp_next);
            chk({nm, "_pc_out"}, pc_out, exp_next);
        end
    endtask

    initial begin
        int total;
        rst       = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;

        tbl[0]  = '{"addi_x1",  32'h00, 32'h00500093, 4, 0, 32'h04, 1,  32'h00000005};
        tbl[1]  = '{"addi_x2",  32'h04, 32'hFF908113, 4, 0, 32'h08, 2,  32'hFFFFFFFE};
        tbl[2]  = '{"add_x3",   32'h08, 32'h002081B3, 4, 0, 32'h0C, 3,  32'h00000003};
        tbl[3]  = '{"sub_x4",   32'h0C, 32'h40208233, 4, 0, 32'h10, 4,  32'h00000007};
        tbl[4]  = '{"and_x10",  32'h10, 32'h0020F533, 4, 0, 32'h14, 10, 32'h00000004};
        tbl[5]  = '{"or_x6",    32'h14, 32'h0020E333, 4, 0, 32'h18, 6,  32'hFFFFFFFF};
        tbl[6]  = '{"slt_x7",   32'h18, 32'h001123B3, 4, 0, 32'h1C, 7,  32'h00000001};
        tbl[7]  = '{"slti_x8",  32'h1C, 32'hFFF0A413, 4, 0, 32'h20, 8,  32'h00000000};
        tbl[8]  = '{"jal_x5",   32'h20, 32'h010002EF, 3, 0, 32'h30, 5,  32'h00000024};
        tbl[9]  = '{"beq",      32'h30, 32'hFE108CE3, 3, 0, 32'h28, -1, 32'h0};
        tbl[10] = '{"bne",      32'h28, 32'h00109463, 3, 0, 32'h2C, -1, 32'h0};
        tbl[11] = '{"jal_x0",   32'h2C, 32'h0140006F, 3, 0, 32'h40, -1, 32'h0};
        tbl[12] = '{"ori_x11",  32'h40, 32'h12306593, 4, 0, 32'h44, 11, 32'h00000123};
        tbl[13] = '{"addi_x0",  32'h44, 32'h00900013, 4, 0, 32'h48, -1, 32'h0};
        tbl[14] = '{"sw_x0",    32'h48, 32'h08002023, 4, 0, 32'h4C, -1, 32'h0};
        tbl[15] = '{"lw_x12",   32'h4C, 32'h08002603, 5, 1, 32'h50, 12, 32'h00000000};
        tbl[16] = '{"andi_x13", 32'h50, 32'h0F037693, 4, 0, 32'h54, 13, 32'h000000F0};

        for (int i = 0; i < 128; i++) mem[i] = 32'h00000013;
        mem[32] = 32'h12345678;
        for (int i = 0; i < 17; i++) mem[tbl[i].pc[8:2]] = tbl[i].instr;
        mem[21] = 32'h0000007F;

        wait_n = 0;
        do_reset();
        total = 0;
        for (int i = 0; i < 17; i++) begin
            int c0;
            c0 = n_chk;
            step(tbl[i].name, tbl[i].cycles, tbl[i].skip, tbl[i].next_pc);
            if (i < 3 && n_chk > c0 + 1) total += tbl[i].cycles;
            if (tbl[i].rd >= 0)
                chk({tbl[i].name, "_rd"}, dut.u_regfile.regs[tbl[i].rd], tbl[i].rd_val);
            if (i == 0) chk("alu_result_addi", alu_result, 32'h5);
            if (i == 2) begin
                n_chk++;
                if (total != 12) begin
                    n_fail++;
                    $display("FAIL first3_total: actual=%0d required=12 cycles (a timeout occurred)", total);
                end
            end
        end
        chk("x0_store_mem", mem[32], 32'h0);

`ifdef MCRV_ILLEGAL_TRAP_EN
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("trap_mem_req", 32'(mem_req), 32'h0);
        end
        chk("trap_halted", 32'(halted), 32'h1);
        chk("trap_pc", pc_out, 32'h58);
`else
        step("illegal_nop", 3, 0, 32'h58);
        chk("nop_halted", 32'(halted), 32'h0);
`endif

        // Wait-state sequence: jal to 0x40, sw x1,8(x0), lw x4,8(x0)
        mem[0]  = 32'h0400006F;
        mem[2]  = 32'hAAAA5555;
        mem[16] = 32'h00102423;
        mem[17] = 32'h00802203;
        mem[18] = 32'h00000013;
        wait_n  = 2;
        do_reset();
        step("w_jal", 5, 0, 32'h40);
        step("w_sw", 8, 0, 32'h44);
        chk("w_sw_mem", mem[2], 32'h5);
        step("w_lw", 9, 1, 32'h48);
        chk("w_lw_x4", dut.u_regfile.regs[4], 32'h5);

        // Reset during a stalled fetch at 0x48
        chk("pre_rst_req", 32'(mem_req), 32'h1);
        rst = 1'b1;
        #1;
        chk("midrst_mem_req", 32'(mem_req), 32'h0);
        chk("midrst_pc", pc_out, 32'h0);
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
